// File: rtl/inv_key_schedule.sv
// AES-128 inverse key scheduler: loaded with round key 10, regenerates keys 10..0 one per handshake.
// Optional INV_KEY_MIXCOL_EN: rounds 9..1 are emitted through InvMixColumns (equivalent inverse cipher).

module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] inv;

  assign inv = ginv(a_i);
  assign s_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module inv_key_schedule (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] last_key,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_round,
  output logic [127:0] rk_data,
  output logic         done
);
  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   round_q, round_d;

  logic [31:0]  kw [4];
  logic [31:0]  p3;
  logic [31:0]  rot_w;
  logic [31:0]  sub_w;
  logic [127:0] prev_key;
  logic [7:0]   rcon_prev;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_word
      assign kw[gi] = key_q[127-32*gi -: 32];
      aes_sbox u_sbox (
        .a_i (rot_w[8*gi +: 8]),
        .s_o (sub_w[8*gi +: 8])
      );
    end
  endgenerate

  assign p3        = kw[3] ^ kw[2];
  assign rot_w     = {p3[23:0], p3[31:24]};
  assign prev_key  = {kw[0] ^ sub_w ^ {rcon_q, 24'h0}, kw[1] ^ kw[0], kw[2] ^ kw[1], p3};
  assign rcon_prev = rcon_q[0] ? (((rcon_q ^ 8'h1b) >> 1) | 8'h80) : (rcon_q >> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      rcon_q  <= 8'h00;
      round_q <= 4'd0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rcon_q  <= rcon_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rcon_d  = rcon_q;
    round_d = round_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = last_key;
          rcon_d  = 8'h36;
          round_d = 4'd10;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (round_q != 4'd0) begin
            key_d   = prev_key;
            rcon_d  = rcon_prev;
            round_d = round_q - 4'd1;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == EMIT);
  assign rk_valid = (state_q == EMIT);
  assign done     = (state_q == DONE);
  assign rk_round = round_q;

`ifdef INV_KEY_MIXCOL_EN
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] imc_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  logic [127:0] mix_key;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_mix
      assign mix_key[127-32*gi -: 32] = imc_col(key_q[127-32*gi -: 32]);
    end
  endgenerate

  // First and last round keys are used raw by the equivalent inverse cipher.
  assign rk_data = (round_q == 4'd0 || round_q == 4'd10) ? key_q : mix_key;
`else
  assign rk_data = key_q;
`endif
endmodule

// File: tb/tb_inv_key_schedule.sv
// Self-checking bench for inv_key_schedule: forward-form key-expansion model, scoreboard queue and monitor.
module tb_inv_key_schedule;
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] last_key;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [3:0]   rk_round;
  logic [127:0] rk_data;
  logic         done;

  inv_key_schedule dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .last_key (last_key),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_round (rk_round),
    .rk_data  (rk_data),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   r;
    logic [127:0] d;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           done_seen = 0;
  int           done_exp = 0;
  logic [7:0]   sbox_t [256];
  logic [127:0] exp_rk [11];
  logic [127:0] cap [11];

  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from log/antilog tables of generator 3, then the affine map.
  function automatic void build_sbox();
    logic [7:0] alog [256];
    int         lg [256];
    logic [7:0] x = 8'h01;
    logic [7:0] b;
    for (int i = 0; i < 255; i++) begin
      alog[i] = x;
      lg[x]   = i;
      x       = gmul(x, 8'h03);
    end
    for (int v = 0; v < 256; v++) begin
      b = (v == 0) ? 8'h00 : alog[(255 - lg[v]) % 255];
      sbox_t[v] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // Fill the 44-word expansion backwards from the last four words.
  function automatic void gen_keys(input logic [127:0] lk);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int j = 0; j < 4; j++) w[40+j] = lk[127-32*j -: 32];
    for (int i = 43; i >= 4; i--) begin
      t = w[i-1];
      if (i % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rc[i/4], 24'h0};
      w[i-4] = w[i] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] k);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = k[127-32*c -: 8];
      a1 = k[119-32*c -: 8];
      a2 = k[111-32*c -: 8];
      a3 = k[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  function automatic logic [127:0] out_form(input int r, input logic [127:0] k);
`ifdef INV_KEY_MIXCOL_EN
    if (r >= 1 && r <= 9) return inv_mix(k);
`endif
    return k;
  endfunction

  // Monitor: pops on every handshake, checks stability while stalled, counts done pulses.
  initial begin
    bit           hold_p = 1'b0;
    logic [3:0]   hold_r = 4'd0;
    logic [127:0] hold_d = '0;
    exp_t         e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_p = 1'b0;
      end else begin
        if (hold_p) begin
          chk("stall_valid", 128'(rk_valid), 128'(1'b1));
          chk("stall_round", 128'(rk_round), 128'(hold_r));
          chk("stall_data", rk_data, hold_d);
        end
        hold_p = 1'b0;
        if (rk_valid && rk_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_key act_round=%0d act=%h exp=none", rk_round, rk_data);
          end else begin
            e = sb.pop_front();
            chk("rk_round", 128'(rk_round), 128'(e.r));
            chk("rk_data", rk_data, e.d);
          end
          if (rk_round <= 4'd10) cap[rk_round] = rk_data;
        end else if (rk_valid) begin
          hold_p = 1'b1;
          hold_r = rk_round;
          hold_d = rk_data;
        end
        if (done) done_seen++;
      end
    end
  end

  // mode 0: ready held high; 1: 5-cycle stall at round 9 then random ready;
  // 2: spurious start at round 6; 3: reset at round 4.
  task automatic run_seq(input logic [127:0] k, input int mode);
    int   vcnt = 0;
    int   stall = 0;
    bit   pulsed = 1'b0;
    bit   hit_rst = 1'b0;
    bit   got_done = 1'b0;
    exp_t e;
    gen_keys(k);
    for (int r = 10; r >= 0; r--) begin
      e.r = 4'(r);
      e.d = out_form(r, exp_rk[r]);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    chk("idle_busy", 128'(busy), 128'(1'b0));
    start    = 1'b1;
    last_key = k;
    @(posedge clk); #1;
    start    = 1'b0;
    last_key = {$urandom, $urandom, $urandom, $urandom};
    chk("lat1_busy", 128'(busy), 128'(1'b1));
    chk("lat1_valid", 128'(rk_valid), 128'(1'b1));
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (rk_valid) vcnt++;
      case (mode)
        0: rk_ready = 1'b1;
        1: begin
          if (rk_round == 4'd9 && stall < 5) begin
            rk_ready = 1'b0;
            stall++;
          end else begin
            rk_ready = 1'($urandom_range(0, 1));
          end
        end
        2: begin
          rk_ready = 1'b1;
          if (rk_round == 4'd6 && !pulsed) begin
            start    = 1'b1;
            last_key = ~k;
            pulsed   = 1'b1;
          end else begin
            start = 1'b0;
          end
        end
        default: begin
          rk_ready = 1'b1;
          if (rk_round == 4'd4) begin
            #1 rst = 1'b1;
            #1;
            chk("rst_busy", 128'(busy), 128'(1'b0));
            chk("rst_valid", 128'(rk_valid), 128'(1'b0));
            chk("rst_done", 128'(done), 128'(1'b0));
            chk("rst_round", 128'(rk_round), 128'(4'd0));
            chk("rst_data", rk_data, 128'd0);
            sb.delete();
            hit_rst = 1'b1;
          end
        end
      endcase
      if (hit_rst) break;
      @(posedge clk); #1;
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (hit_rst) begin
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_done", 128'(done), 128'(1'b0));
      chk("post_rst_busy", 128'(busy), 128'(1'b0));
    end else if (got_done) begin
      done_exp++;
      chk("done_busy", 128'(busy), 128'(1'b0));
      chk("done_valid", 128'(rk_valid), 128'(1'b0));
      if (mode == 0) chk("valid_cycles", 128'(vcnt), 128'(11));
    end else begin
      checks++;
      errors++;
      $display("FAIL timeout act=no_done exp=done mode=%0d", mode);
    end
  endtask

  task automatic chk_fips(input string tag);
    chk({tag, "_r10"}, cap[10], FIPS_K10);
    chk({tag, "_r9"}, cap[9], out_form(9, FIPS_K9));
    chk({tag, "_r1"}, cap[1], out_form(1, FIPS_K1));
    chk({tag, "_r0"}, cap[0], FIPS_K0);
  endtask

  initial begin
    build_sbox();
    rst      = 1'b1;
    start    = 1'b0;
    rk_ready = 1'b0;
    last_key = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 128'(busy), 128'(1'b0));
    chk("reset_valid", 128'(rk_valid), 128'(1'b0));
    chk("reset_done", 128'(done), 128'(1'b0));
    chk("reset_round", 128'(rk_round), 128'(4'd0));
    chk("reset_data", rk_data, 128'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) cap[i] = '0;
    run_seq(FIPS_K10, 0);
    chk_fips("fips");

    for (int i = 0; i < 11; i++) cap[i] = '0;
    run_seq(FIPS_K10, 1);
    chk_fips("bp");

    run_seq({$urandom, $urandom, $urandom, $urandom}, 2);
    run_seq({$urandom, $urandom, $urandom, $urandom}, 3);
    run_seq({$urandom, $urandom, $urandom, $urandom}, 0);
    run_seq({$urandom, $urandom, $urandom, $urandom}, 0);
    for (int n = 0; n < 6; n++) run_seq({$urandom, $urandom, $urandom, $urandom}, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 128'(sb.size()), 128'd0);
    chk("done_count", 128'(done_seen), 128'(done_exp));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
